// File: rtl/spi_ram_arbiter.sv
// Two-port (fetch / data) arbiter serialising 32-bit word accesses onto one SPI RAM (03h read, 02h write).
// Define SPI_RAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 1 has fixed priority.
module spi_ram_arbiter #(
    parameter int ADDR_W       = 22,
    parameter int DESEL_PULSES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              ack1,
    output logic [31:0]       rdata,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              spi_select,
    input  logic              spi_miso
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_ACK, S_DESEL} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_phase;
    logic [4:0]        r_bit;
    logic [15:0]       r_desel;
    logic              r_port;
    logic              r_write;
    logic [31:0]       r_shift;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              w_grant;
    logic              w_sel1;
    logic              w_last_bit;
    logic              w_desel_done;
    logic [ADDR_W-1:0] w_addr;
    logic [23:0]       w_byte_addr;

    assign w_grant = req0 | req1;

`ifdef SPI_RAM_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= 1'b1;
        else if (r_state == S_IDLE && w_grant)
            r_last <= w_sel1;
    end

    // On a tie the port that was not served last wins.
    assign w_sel1 = req1 & (~req0 | ~r_last);
`else
    assign w_sel1 = req1;
`endif

    assign w_addr       = w_sel1 ? addr1 : addr0;
    assign w_byte_addr  = 24'({w_addr, 2'b00});
    assign w_last_bit   = r_phase && (r_bit == 5'd31);
    assign w_desel_done = r_phase && (r_desel == 16'(DESEL_PULSES - 1));
    assign rdata        = r_rdata;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_DESEL;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant)      w_next = S_HDR;
            S_HDR:   if (w_last_bit)   w_next = S_DATA;
            S_DATA:  if (w_last_bit)   w_next = S_ACK;
            S_ACK:                     w_next = S_DESEL;
            S_DESEL: if (w_desel_done) w_next = S_IDLE;
            default:                   w_next = S_DESEL;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        spi_select = 1'b1;
        spi_clk    = 1'b0;
        spi_mosi   = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        case (r_state)
            S_HDR: begin
                spi_select = 1'b0;
                spi_clk    = r_phase;
                spi_mosi   = r_shift[31];
            end
            S_DATA: begin
                spi_select = 1'b0;
                spi_clk    = r_phase;
                spi_mosi   = r_write & r_shift[0];
            end
            S_ACK: begin
                ack0 = ~r_port;
                ack1 = r_port;
            end
            S_DESEL: spi_clk = r_phase;
            default: ;
        endcase
    end

    // Shifts happen at the edge ending each high phase, i.e. on entry to the next low phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_bit   <= 5'd0;
            r_desel <= 16'd0;
            r_port  <= 1'b0;
            r_write <= 1'b0;
            r_shift <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_phase <= 1'b0;
                    r_bit   <= 5'd0;
                    r_desel <= 16'd0;
                    if (w_grant) begin
                        r_port  <= w_sel1;
                        r_write <= w_sel1 & we1;
                        r_wdata <= wdata1;
                        r_shift <= {((w_sel1 & we1) ? 8'h02 : 8'h03), w_byte_addr};
                    end
                end
                S_HDR, S_DATA: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_bit <= r_bit + 5'd1;
                        if (r_state == S_HDR) begin
                            r_shift <= (r_bit == 5'd31) ? (r_write ? r_wdata : 32'd0)
                                                        : {r_shift[30:0], 1'b0};
                        end else begin
                            r_shift <= {spi_miso, r_shift[31:1]};
                            if (r_bit == 5'd31 && !r_write)
                                r_rdata <= {spi_miso, r_shift[31:1]};
                        end
                    end
                end
                S_DESEL: begin
                    r_phase <= ~r_phase;
                    if (r_phase)
                        r_desel <= r_desel + 16'd1;
                end
                default: r_phase <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter: behavioural SPI RAM, protocol monitor and a
// transaction-level reference model of arbitration, timing and memory contents.
module tb_spi_ram_arbiter;

    localparam int ADDR_W       = 22;
    localparam int DESEL_PULSES = 1;
    localparam int LAT          = 129;                   // IDLE grant cycle to ack cycle (130 cycles inclusive)
    localparam int GAP          = 130 + 2 * DESEL_PULSES; // ack-to-ack spacing with a request pending
`ifdef SPI_RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              ack0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [31:0]       wdata1;
    logic              ack1;
    logic [31:0]       rdata;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_select;
    logic              spi_miso;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    spi_ram_arbiter #(.ADDR_W(ADDR_W), .DESEL_PULSES(DESEL_PULSES)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_select(spi_select), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] init_val(input int i);
        return (i == 5) ? 32'h0000_0001 : ((32'h9E37_79B9 * 32'(i + 1)) ^ 32'h0F0F_0000);
    endfunction

    function automatic logic [31:0] exp_hdr(input bit wr, input logic [ADDR_W-1:0] a);
        logic [23:0] byte_addr = {a, 2'b00};
        return {(wr ? 8'h02 : 8'h03), byte_addr};
    endfunction

    // Behavioural SPI RAM: samples mosi on rising spi_clk, drives miso for the bit being clocked.
    logic [31:0] ram_mem [0:63];
    logic [31:0] hdr_log [$];
    bit          ram_init = 1'b0;
    logic [31:0] shdr;
    logic [31:0] wword;
    logic [31:0] rword;
    logic        psclk;
    int          bit_n;
    int          widx;

    always @(negedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 64; i++) ram_mem[i] = init_val(i);
            ram_init = 1'b1;
        end
        if (spi_select !== 1'b0) begin
            bit_n    = 0;
            spi_miso = 1'b0;
        end else if (spi_clk === 1'b1 && psclk === 1'b0) begin
            if (bit_n < 32) begin
                shdr = {shdr[30:0], spi_mosi};
            end else if (bit_n < 64) begin
                widx = int'(shdr[23:2]);
                wword[bit_n-32] = spi_mosi;
                if (shdr[31:24] == 8'h03 && widx < 64) begin
                    rword    = ram_mem[widx];
                    spi_miso = rword[bit_n-32];
                end
                if (bit_n == 63 && shdr[31:24] == 8'h02 && widx < 64) ram_mem[widx] = wword;
            end
            bit_n++;
            if (bit_n == 32) hdr_log.push_back(shdr);
        end
        psclk = spi_clk;
    end

    // Protocol monitor: select steady while spi_clk high, 64 rising edges per selected transfer.
    logic rst_q;
    logic prev_sclk;
    logic prev_sel;
    bit   aborted = 1'b0;
    int   sel_rises = 0;
    int   desel_rises = 0;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (cyc > 4) begin
            if (rst_q && prev_sel === 1'b0) aborted = 1'b1;
            if (spi_clk === 1'b1) check("sel_stable_sclk_high", 32'(spi_select), 32'(prev_sel));
            if (spi_clk === 1'b1 && prev_sclk === 1'b0) begin
                if (spi_select === 1'b1) desel_rises++;
                else sel_rises++;
            end
            if (spi_select === 1'b1 && prev_sel === 1'b0) begin
                if (!aborted) check("sclk_rises_per_txn", 32'(sel_rises), 32'd64);
                sel_rises = 0;
                aborted   = 1'b0;
            end
        end
        prev_sclk = spi_clk;
        prev_sel  = spi_select;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state.
    logic [31:0] ref_mem [0:63];
    bit          rr_last = 1'b1;
    int          hdr_rd  = 0;

    task automatic wait_ack(output int p, output int t);
        p = -1;
        t = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                p = (ack1 === 1'b1) ? 1 : 0;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic check_hdr(input bit wr, input logic [ADDR_W-1:0] a);
        check("spi_header_logged", 32'(hdr_log.size() > hdr_rd), 32'd1);
        if (hdr_log.size() > hdr_rd) begin
            check("spi_header", hdr_log[hdr_rd], exp_hdr(wr, a));
            hdr_rd++;
        end
    endtask

    // Present up to one request per port in the same IDLE cycle and check every consequence.
    task automatic run_pair(input bit do0, input logic [ADDR_W-1:0] a0,
                            input bit do1, input bit w1, input logic [ADDR_W-1:0] a1,
                            input logic [31:0] d1);
        int first, p, t, t_prev, npend, exp_p;
        @(negedge clk);
        req0 = do0; addr0 = a0;
        req1 = do1; we1 = w1; addr1 = a1; wdata1 = d1;
        t_prev = cyc;
        if (do0 && do1) first = (!RR || !rr_last) ? 1 : 0;
        else first = do1 ? 1 : 0;
        npend = int'(do0) + int'(do1);
        for (int k = 0; k < npend; k++) begin
            exp_p = (k == 0) ? first : 1 - first;
            wait_ack(p, t);
            check("ack_port", 32'(p), 32'(exp_p));
            check("ack_timing", 32'(t - t_prev), 32'((k == 0) ? LAT : GAP));
            t_prev  = t;
            rr_last = exp_p[0];
            if (exp_p == 0) begin
                check_hdr(1'b0, a0);
                check("rdata_port0", rdata, ref_mem[a0[5:0]]);
                req0 = 1'b0;
            end else begin
                check_hdr(w1, a1);
                if (w1) begin
                    ref_mem[a1[5:0]] = d1;
                    check("ram_commit", ram_mem[a1[5:0]], d1);
                end else begin
                    check("rdata_port1", rdata, ref_mem[a1[5:0]]);
                end
                req1 = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int p, t, t0, d_prev, mode, seen;
        bit w;
        logic [ADDR_W-1:0] ra0, ra1;

        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata1 = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_spi_select", 32'(spi_select), 32'd1);
        check("rst_spi_clk",    32'(spi_clk),    32'd0);
        check("rst_spi_mosi",   32'(spi_mosi),   32'd0);
        check("rst_ack0",       32'(ack0),       32'd0);
        check("rst_ack1",       32'(ack1),       32'd0);
        check("rst_rdata",      rdata,           32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Two simultaneous-request ties.
        run_pair(1'b1, 22'd3, 1'b1, 1'b0, 22'd9, 32'd0);
        run_pair(1'b1, 22'd4, 1'b1, 1'b0, 22'd11, 32'd0);

        // Write then read back through the other port.
        run_pair(1'b0, 22'd0, 1'b1, 1'b1, 22'h10, 32'hDEAD_BEEF);
        run_pair(1'b1, 22'h10, 1'b0, 1'b0, 22'd0, 32'd0);

        // Bit order: word 5 holds 0x00000001.
        run_pair(1'b1, 22'd5, 1'b0, 1'b0, 22'd0, 32'd0);

        // Back-to-back port 0 reads with the request held high.
        @(negedge clk);
        req0 = 1'b1; addr0 = 22'd0;
        t0 = cyc; d_prev = desel_rises;
        for (int i = 0; i < 3; i++) begin
            wait_ack(p, t);
            check("b2b_port", 32'(p), 32'd0);
            check("b2b_timing", 32'(t - t0), 32'((i == 0) ? LAT : GAP));
            check("b2b_rdata", rdata, ref_mem[i]);
            check_hdr(1'b0, 22'(i));
            if (i > 0) check("b2b_desel_pulses", 32'(desel_rises - d_prev), 32'(DESEL_PULSES));
            t0 = t; d_prev = desel_rises; rr_last = 1'b0;
            if (i == 2) req0 = 1'b0;
            else addr0 = 22'(i + 1);
        end
        repeat (4) @(negedge clk);

        // Reset during header bit 20 of a write to word 7.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 22'd7; wdata1 = 32'h1234_5678;
        t0 = cyc;
        while (cyc < t0 + 1 + 2 * 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_spi_select", 32'(spi_select), 32'd1);
        check("abort_spi_clk",    32'(spi_clk),    32'd0);
        rst = 1'b0; req1 = 1'b0; we1 = 1'b0; rr_last = 1'b1;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) seen++;
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        check("abort_ram_unchanged", ram_mem[7], ref_mem[7]);
        run_pair(1'b1, 22'd7, 1'b0, 1'b0, 22'd0, 32'd0);

        // Randomised mix of single and simultaneous requests.
        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 2);
            ra0  = 22'($urandom_range(0, 63));
            ra1  = 22'($urandom_range(0, 63));
            w    = 1'($urandom_range(0, 1));
            run_pair(mode != 1, ra0, mode != 0, w, ra1, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
